// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Two-stage pipelined barrel shifter covering LSL/LSR/ASR/ROR with
//   immediate and register-specified amounts, plus an immediate-rotate mode
//   that rotates by an even amount.
//
//   Stage 1 registers the request together with a normalised operation kind
//   and an amount in 0..WIDTH. All out-of-range cases are folded into these
//   fields here. Stage 2 then only performs well-defined shifts and registers
//   out_data/out_cout.
//
// Ports
//   clk, rst_n         single rising-edge clock, asynchronous active-low reset
//   flush              synchronous discard of both pipeline stages
//   in_valid/in_ready  request handshake
//   in_imm, in_op      immediate-rotate mode / shift opcode
//   in_data, in_amt    shiftee and shift amount
//   in_cin             carry flag travelling with the request
//   out_valid/out_ready result handshake
//   out_data, out_cout result and carry out
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that
// transfer. in_ready is derived from pipeline state and flush only; it never
// depends on in_valid.
module barrel_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_imm,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);

  localparam int LOGW = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
  localparam logic [LOGW:0]    W_N   = (LOGW+1)'(WIDTH);

  // normalised operation kinds carried from stage 1 to stage 2
  localparam logic [2:0] K_PASS = 3'd0;  // x, c
  localparam logic [2:0] K_ZERO = 3'd1;  // 0, 0
  localparam logic [2:0] K_LSL  = 3'd2;
  localparam logic [2:0] K_LSR  = 3'd3;
  localparam logic [2:0] K_ASR  = 3'd4;
  localparam logic [2:0] K_ROR  = 3'd5;  // cout = result msb
  localparam logic [2:0] K_RRX  = 3'd6;

  logic             s1_valid;
  logic [2:0]       s1_kind;
  logic [LOGW:0]    s1_n;
  logic [WIDTH-1:0] s1_data;
  logic             s1_cin;

  logic       s1_adv;
  logic       accept;
  logic [2:0] d_kind;
  logic [LOGW:0] d_n;

  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = rst_n & ~flush & (~s1_valid | s1_adv);
  assign accept   = in_valid & in_ready;

  // ---------------- stage 1 decode ----------------
  logic [LOGW-1:0] lo;
  logic [LOGW-1:0] imm_rot;
  logic            amt_zero;
  logic            amt_over;
  logic            amt_ge;

  always_comb begin
    lo       = in_amt[LOGW-1:0];
    imm_rot  = {in_amt[LOGW-2:0], 1'b0};
    amt_zero = (in_amt == '0);
    amt_over = (in_amt > W_AMT);
    amt_ge   = (in_amt >= W_AMT);
    d_kind   = K_PASS;
    d_n      = '0;
    if (in_imm) begin
      // rotate by 2*amt mod W; zero rotation keeps the incoming carry
      if (imm_rot != '0) begin
        d_kind = K_ROR;
        d_n    = {1'b0, imm_rot};
      end
    end else begin
      case (in_op)
        3'b000: if (lo != '0) begin d_kind = K_LSL; d_n = {1'b0, lo}; end
        3'b001: begin
          if (amt_over) d_kind = K_ZERO;
          else if (!amt_zero) begin d_kind = K_LSL; d_n = in_amt[LOGW:0]; end
        end
        // immediate amount 0 encodes a full-width shift
        3'b010: begin d_kind = K_LSR; d_n = (lo == '0) ? W_N : {1'b0, lo}; end
        3'b011: begin
          if (amt_over) d_kind = K_ZERO;
          else if (!amt_zero) begin d_kind = K_LSR; d_n = in_amt[LOGW:0]; end
        end
        3'b100: begin d_kind = K_ASR; d_n = (lo == '0) ? W_N : {1'b0, lo}; end
        3'b101: begin
          if (amt_ge) begin d_kind = K_ASR; d_n = W_N; end
          else if (!amt_zero) begin d_kind = K_ASR; d_n = in_amt[LOGW:0]; end
        end
        3'b110: begin
          if (lo == '0) d_kind = K_RRX;
          else begin d_kind = K_ROR; d_n = {1'b0, lo}; end
        end
        default: begin
          // a nonzero multiple of W rotates by 0; cout is then x[W-1]
          if (!amt_zero) begin d_kind = K_ROR; d_n = {1'b0, lo}; end
        end
      endcase
    end
  end

  // ---------------- stage 2 datapath ----------------
  // One extra bit beside the data catches the last bit shifted out, so the
  // carry never needs a computed index into x.
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   asr_w;
  logic [LOGW-1:0]  rot_r;
  logic [LOGW:0]    rot_l;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] res;
  logic             res_c;

  always_comb begin
    lsl_w = {1'b0, s1_data} << s1_n;
    lsr_w = {s1_data, 1'b0} >> s1_n;
    asr_w = $signed({s1_data, 1'b0}) >>> s1_n;
    rot_r = s1_n[LOGW-1:0];
    rot_l = W_N - {1'b0, rot_r};
    rot   = (s1_data >> rot_r) | (s1_data << rot_l);
    res   = s1_data;
    res_c = s1_cin;
    case (s1_kind)
      K_ZERO: begin res = '0;                 res_c = 1'b0;         end
      K_LSL:  begin res = lsl_w[WIDTH-1:0];   res_c = lsl_w[WIDTH]; end
      K_LSR:  begin res = lsr_w[WIDTH:1];     res_c = lsr_w[0];     end
      K_ASR:  begin res = asr_w[WIDTH:1];     res_c = asr_w[0];     end
      K_ROR:  begin res = rot;                res_c = rot[WIDTH-1]; end
      K_RRX:  begin res = {s1_cin, s1_data[WIDTH-1:1]}; res_c = s1_data[0]; end
      default: begin res = s1_data;           res_c = s1_cin;       end
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_kind   <= K_PASS;
      s1_n      <= '0;
      s1_data   <= '0;
      s1_cin    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cout  <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_kind  <= d_kind;
        s1_n     <= d_n;
        s1_data  <= in_data;
        s1_cin   <= in_cin;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // output registers only change on a load, so a stalled result holds
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_cout  <= res_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
